lif_array_scheduler: RTL and testbench
======================================

Name: lif_array_scheduler

Overview:
- Time-multiplexed controller that evaluates N_NEURONS virtual LIF neurons with one shared update datapath, one neuron per accepted input current.
- Holds per-neuron membrane state, threshold and leak configuration.
- Sequences one timestep per start pulse and publishes a spike vector on completion.
- Sits between the input-current source (valid/ready stream) and downstream spike consumers.

Parameters:
- N_NEURONS, 8, number of virtual neurons (2..64).
- IDX_W, $clog2(N_NEURONS), neuron index width.
- THRESH_RST, 230, threshold value loaded at reset.
- REFRAC_STEPS, 2, refractory length in timesteps (used only with LIF_REFRACTORY_EN; 1..15).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin one timestep; honoured only in IDLE.
- cur_valid  in  1  input current valid.
- cur_data  in  8  unsigned current for neuron cur_idx.
- cur_ready  out  1  high in RUN only.
- cur_idx  out  IDX_W  neuron the next accepted current is applied to.
- cfg_we  in  1  configuration write; honoured only in IDLE.
- cfg_thresh  in  8  threshold written on cfg_we.
- cfg_decay  in  2  leak mode written on cfg_we.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse in DONE.
- spike_vec  out  N_NEURONS  spikes of the last completed timestep; bit i = neuron i.
- rd_idx  in  IDX_W  state readback select.
- rd_state  out  8  combinational read of state[rd_idx]; rd_idx >= N_NEURONS returns 0.

Behaviour:
- Reset (rst_n low at a clk edge): FSM=IDLE, all state[i]=0, threshold=THRESH_RST, decay=2, spike_vec=0, cur_idx=0, done=0, busy=0, cur_ready=0. Reset mid-timestep aborts it; no done pulse is issued.
- FSM IDLE -> RUN: on start. cur_idx=0; internal spike accumulator cleared.
- FSM RUN: cur_ready=1. A transfer is cur_valid & cur_ready at a clk edge. Each transfer updates neuron cur_idx in that same edge, then increments cur_idx. cur_valid low stalls with no state change.
- FSM RUN -> DONE: on the transfer with cur_idx=N_NEURONS-1.
- FSM DONE: single cycle. done=1; spike_vec is loaded from the accumulator at the entry edge and is visible during DONE; busy=1. Then -> IDLE with cur_idx=0.
- Per-neuron update, U = state[i], I = cur_data:
  - spike_i = (U >= threshold), unsigned compare.
  - If spike_i: state[i] <= 0. Otherwise state[i] <= min(255, I + leak(U)), using a 9-bit sum saturated to 8 bits.
  - leak(U) by decay mode: 0 -> U>>1; 1 -> (U>>1)+(U>>2); 2 -> (U>>1)+(U>>2)+(U>>3); 3 -> 0. Each shift term is truncated.
  - spike_i is written to accumulator bit i.
- Latency: timestep completes N_NEURONS transfers after start. Minimum start-to-done is N_NEURONS+1 cycles.
- start in RUN/DONE is ignored. cfg_we outside IDLE is ignored.
- start and cfg_we in the same IDLE cycle: config is written and the timestep uses the new config.
- spike_vec holds its value until the next DONE.
- threshold=0 makes every neuron spike every timestep. threshold=255 spikes only at U=255.

Optional Feature:
- Macro: LIF_REFRACTORY_EN.
- Defined: each neuron has a 4-bit refractory counter, reset to 0.
  - On a spike the counter loads REFRAC_STEPS.
  - While the counter is nonzero at that neuron's transfer: input is ignored, state stays 0, spike_i=0, and the counter decrements.
  - Counter clears on reset.
- Not defined: no counters; behaviour exactly as above.

Test Plan:
- Reset then readback: rd_state=0 for all i, spike_vec=0, cur_ready=0, threshold effective 230.
- Defaults, neuron0 fed 100 every step, others 0. State after steps 1..3 = 100, 187, 255 (saturated), spike_vec=0. Step 4 -> spike_vec[0]=1, state0=0.
- Decay mode 3, thresh 50, current 60 to all. Step 1 -> state=60, no spikes. Step 2 -> spike_vec=all ones, states 0.
- Stall: cur_valid held low 5 cycles mid-RUN -> cur_idx and states frozen, done delayed exactly 5 cycles.
- Illegal ops: start and cfg_we (thresh 10) asserted during RUN -> ignored, threshold still 230. rst_n low mid-RUN -> IDLE, states 0, no done pulse.
- LIF_REFRACTORY_EN, REFRAC_STEPS=2, thresh 50, decay 3, current 60: neuron spikes on step 2, is held at 0 on steps 3-4, reaches state 60 on step 5, spikes again on step 6.

Source files
------------

// File: rtl/lif_array_scheduler.sv
// lif_array_scheduler: time-multiplexed LIF neuron array, one shared update per accepted current.
// Optional LIF_REFRACTORY_EN adds a per-neuron refractory counter.
module lif_array_scheduler #(
    parameter int N_NEURONS    = 8,
    parameter int IDX_W        = $clog2(N_NEURONS),
    parameter int THRESH_RST   = 230,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cur_valid,
    input  logic [7:0]           cur_data,
    output logic                 cur_ready,
    output logic [IDX_W-1:0]     cur_idx,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_thresh,
    input  logic [1:0]           cfg_decay,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [7:0]           rd_state
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

    state_t               r_st, w_nxt;
    logic [7:0]           r_mem [N_NEURONS];
    logic [7:0]           r_thresh;
    logic [1:0]           r_decay;
    logic [IDX_W-1:0]     r_idx;
    logic [N_NEURONS-1:0] r_acc, r_spike_vec, w_acc_nxt;
    logic [7:0]           w_u, w_leak, w_sat;
    logic [8:0]           w_sum;
    logic                 w_xfer, w_hold, w_spike;

    assign w_xfer = (r_st == RUN) && cur_valid;
    assign w_u    = r_mem[r_idx];
    // Leak keeps 1/2, 3/4 or 7/8 of U using truncated shift terms; mode 3 forgets U entirely.
    assign w_leak = (r_decay == 2'd3) ? 8'd0 :
                    (w_u >> 1) + ((r_decay != 2'd0) ? (w_u >> 2) : 8'd0)
                               + ((r_decay == 2'd2) ? (w_u >> 3) : 8'd0);
    assign w_sum   = {1'b0, cur_data} + {1'b0, w_leak};
    assign w_sat   = w_sum[8] ? 8'hFF : w_sum[7:0];
    assign w_spike = !w_hold && (w_u >= r_thresh);

`ifdef LIF_REFRACTORY_EN
    logic [3:0] r_ref [N_NEURONS];

    assign w_hold = r_ref[r_idx] != 4'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) r_ref[i] <= 4'd0;
        end else if (w_xfer) begin
            r_ref[r_idx] <= w_hold ? r_ref[r_idx] - 4'd1 : (w_spike ? 4'(REFRAC_STEPS) : 4'd0);
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_acc_nxt        = r_acc;
        w_acc_nxt[r_idx] = w_spike;
        w_nxt = (r_st == IDLE) ? (start ? RUN : IDLE) :
                (r_st == RUN)  ? ((w_xfer && r_idx == LAST) ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st        <= IDLE;
            r_idx       <= '0;
            r_thresh    <= 8'(THRESH_RST);
            r_decay     <= 2'd2;
            r_acc       <= '0;
            r_spike_vec <= '0;
            for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= 8'd0;
        end else begin
            r_st <= w_nxt;
            if (r_st == IDLE && cfg_we) begin
                r_thresh <= cfg_thresh;
                r_decay  <= cfg_decay;
            end
            if (r_st == IDLE && start) begin
                r_idx <= '0;
                r_acc <= '0;
            end
            if (r_st == DONE) r_idx <= '0;
            if (w_xfer) begin
                r_mem[r_idx] <= (w_hold || w_spike) ? 8'd0 : w_sat;
                r_acc        <= w_acc_nxt;
                r_idx        <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                if (r_idx == LAST) r_spike_vec <= w_acc_nxt;
            end
        end
    end

    assign cur_ready = r_st == RUN;
    assign cur_idx   = r_idx;
    assign busy      = r_st != IDLE;
    assign done      = r_st == DONE;
    assign spike_vec = r_spike_vec;
    assign rd_state  = (32'(rd_idx) < N_NEURONS) ? r_mem[rd_idx] : 8'd0;
endmodule

// File: tb/tb_lif_array_scheduler.sv
// tb_lif_array_scheduler: directed checks of lif_array_scheduler with hand-computed expectations.
module tb_lif_array_scheduler;
    logic       clk = 0, rst_n = 0, start = 0, cur_valid = 0, cfg_we = 0;
    logic [7:0] cur_data = 0, cfg_thresh = 0;
    logic [1:0] cfg_decay = 0;
    logic [2:0] rd_idx = 0;
    logic       cur_ready, busy, done;
    logic [2:0] cur_idx;
    logic [7:0] spike_vec, rd_state;
    int         n_err = 0, n_chk = 0;

    lif_array_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cur_valid(cur_valid), .cur_data(cur_data),
        .cur_ready(cur_ready), .cur_idx(cur_idx), .cfg_we(cfg_we), .cfg_thresh(cfg_thresh),
        .cfg_decay(cfg_decay), .busy(busy), .done(done), .spike_vec(spike_vec),
        .rd_idx(rd_idx), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic chk_states(input string tag, input logic [7:0] e0, input logic [7:0] er);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1 chk($sformatf("%s_st%0d", tag, i), rd_state, (i == 0) ? e0 : er);
        end
    endtask

    // Runs one timestep; optional stall before neuron stall_at, with illegal start/cfg pokes during it.
    task automatic step(input string tag, input logic [7:0] c0, input logic [7:0] cr,
                        input int stall_at, input int stall_len, input bit poke);
        int lat;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; cfg_we = 0; lat = 0;
        chk({tag, "_rdy"}, cur_ready, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    cur_valid = 0;
                    start = poke; cfg_we = poke; cfg_thresh = 8'd10; cfg_decay = 2'd3;
                    @(negedge clk); lat++;
                    start = 0; cfg_we = 0;
                    chk({tag, "_stall_idx"}, cur_idx, i);
                end
            end
            chk({tag, "_idx"}, cur_idx, i);
            cur_valid = 1; cur_data = (i == 0) ? c0 : cr;
            @(negedge clk); lat++;
        end
        cur_valid = 0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_lat"}, lat, 8 + stall_len);
        @(negedge clk);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        do_reset();
        chk_states("rst", 0, 0);
        chk("rst_spk", spike_vec, 0);
        chk("rst_rdy", cur_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", cur_idx, 0);

        // defaults: decay 2, threshold 230
        step("d1", 100, 0, -1, 0, 0); chk_states("d1", 100, 0); chk("d1_spk", spike_vec, 0);
        step("d2", 100, 0, -1, 0, 0); chk_states("d2", 187, 0); chk("d2_spk", spike_vec, 0);
        step("d3", 100, 0, -1, 0, 0); chk_states("d3", 255, 0); chk("d3_spk", spike_vec, 0);
        step("d4", 100, 0, -1, 0, 0); chk_states("d4", 0, 0);   chk("d4_spk", spike_vec, 8'h01);

        // start/cfg during RUN must be ignored: threshold stays 230, decay stays 2
        do_reset();
        step("il1", 200, 0, 4, 1, 1); chk_states("il1", 200, 0);
        step("il2", 0, 0, -1, 0, 0);  chk_states("il2", 175, 0); chk("il2_spk", spike_vec, 0);

        // stall of 5 cycles before neuron 3
        step("stl", 0, 0, 3, 5, 0); chk_states("stl", 151, 0); chk("stl_spk", spike_vec, 0);

        // reset in the middle of a timestep
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; cur_valid = 1; cur_data = 50;
        repeat (3) @(negedge clk);
        cur_valid = 0; rst_n = 0;
        @(negedge clk); rst_n = 1;
        chk("mr_busy", busy, 0);
        chk("mr_rdy", cur_ready, 0);
        chk("mr_idx", cur_idx, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("mr_nodone", done, 0);
        end
        chk_states("mr", 0, 0);

        // thresh 50, decay 3, config written in the same cycle as start
        cfg_we = 1; cfg_thresh = 50; cfg_decay = 3;
        step("m1", 60, 60, -1, 0, 0); chk_states("m1", 60, 60); chk("m1_spk", spike_vec, 0);
        step("m2", 60, 60, -1, 0, 0); chk_states("m2", 0, 0);   chk("m2_spk", spike_vec, 8'hFF);
`ifdef LIF_REFRACTORY_EN
        step("m3", 60, 60, -1, 0, 0); chk_states("m3", 0, 0);   chk("m3_spk", spike_vec, 0);
        step("m4", 60, 60, -1, 0, 0); chk_states("m4", 0, 0);   chk("m4_spk", spike_vec, 0);
        step("m5", 60, 60, -1, 0, 0); chk_states("m5", 60, 60); chk("m5_spk", spike_vec, 0);
        step("m6", 60, 60, -1, 0, 0); chk_states("m6", 0, 0);   chk("m6_spk", spike_vec, 8'hFF);
`else
        step("m3", 60, 60, -1, 0, 0); chk_states("m3", 60, 60); chk("m3_spk", spike_vec, 0);
        step("m4", 60, 60, -1, 0, 0); chk_states("m4", 0, 0);   chk("m4_spk", spike_vec, 8'hFF);
`endif

        // threshold 0: everything spikes even at U=0
        do_reset();
        @(negedge clk); cfg_we = 1; cfg_thresh = 0; cfg_decay = 3;
        @(negedge clk); cfg_we = 0;
        step("t0", 40, 40, -1, 0, 0); chk_states("t0", 0, 0); chk("t0_spk", spike_vec, 8'hFF);

        // threshold 255: spikes only once U saturates at 255
        do_reset();
        cfg_we = 1; cfg_thresh = 255; cfg_decay = 2;
        step("tf1", 255, 0, -1, 0, 0); chk_states("tf1", 255, 0); chk("tf1_spk", spike_vec, 0);
        step("tf2", 0, 0, -1, 0, 0);   chk_states("tf2", 0, 0);   chk("tf2_spk", spike_vec, 8'h01);
        @(negedge clk);
        chk("hold_spk", spike_vec, 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
